// File: rtl/fifo_pkg.sv
// Shared definitions for the single/dual port FIFO family: width helpers,
// the pop-count type and the error codes.
package fifo_pkg;

    // Pointer width for a power-of-two queue, never narrower than 1 bit.
    function automatic int ptr_width(input int qsize);
        return (qsize > 1) ? $clog2(qsize) : 1;
    endfunction

    // Count width: one extra bit so "full" is distinct from "empty".
    function automatic int cnt_width(input int qsize);
        return $clog2(qsize) + 1;
    endfunction

    // Number of entries leaving the queue in one cycle (0, 1 or 2).
    typedef logic [1:0] npop_t;

    // Error codes reported by the FIFO family.
    typedef enum logic [0:0] {
        ERR_NONE  = 1'b0,
        ORDER_ERR = 1'b1
    } fifo_err_e;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping for a FIFO with one push and up to two
// in-order pops per cycle. Flags depend on registered count only.
//
// Handshake: a push happens when i_enque_en && o_in_valid; a head pop when
// i_deque_a && o_a_valid; a second pop only alongside a head pop and only
// when o_b_valid. Requests that do not meet these terms are ignored.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int QUEUE_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_enque_en,
    input  logic                              i_deque_a,
    input  logic                              i_deque_b,
    output logic [ptr_width(QUEUE_SIZE)-1:0]  o_head,
    output logic [ptr_width(QUEUE_SIZE)-1:0]  o_tail,
    output logic [cnt_width(QUEUE_SIZE)-1:0]  o_cnt,
    output logic                              o_push,
    output logic                              o_in_valid,
    output logic                              o_a_valid,
    output logic                              o_b_valid
);

    localparam int PW = ptr_width(QUEUE_SIZE);
    localparam int CW = cnt_width(QUEUE_SIZE);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_cnt;

    logic  w_in_valid;
    logic  w_a_valid;
    logic  w_b_valid;
    logic  w_push;
    logic  w_pop_a;
    logic  w_pop_b;
    npop_t w_npop;

    assign w_in_valid = (r_cnt < CW'(QUEUE_SIZE));
    assign w_a_valid  = (r_cnt != '0);
    assign w_b_valid  = (r_cnt > CW'(1));

    // Full check uses the registered count: no same-cycle pop bypass.
    assign w_push  = i_enque_en && w_in_valid;
    assign w_pop_a = i_deque_a && w_a_valid;
    assign w_pop_b = w_pop_a && i_deque_b && w_b_valid;
    assign w_npop  = npop_t'({1'b0, w_pop_a}) + npop_t'({1'b0, w_pop_b});

    // Advance pointers and count; pointers wrap naturally at QUEUE_SIZE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= r_head + PW'(w_npop);
            r_tail <= r_tail + PW'(w_push);
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_npop);
        end
    end

    assign o_head     = r_head;
    assign o_tail     = r_tail;
    assign o_cnt      = r_cnt;
    assign o_push     = w_push;
    assign o_in_valid = w_in_valid;
    assign o_a_valid  = w_a_valid;
    assign o_b_valid  = w_b_valid;

`ifndef SYNTHESIS
    a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= CW'(QUEUE_SIZE));
    a_cnt_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        (CW+1)'(w_npop) <= {1'b0, r_cnt});
    a_ptr_cnt : assert property (@(posedge clk) disable iff (!rst_n)
        PW'(r_tail - r_head) == r_cnt[PW-1:0]);
`endif

endmodule

// File: rtl/fifo_dual_deq.sv
// Single-enqueue, dual-dequeue FIFO: the two oldest entries are presented
// together and the consumer may pop 0, 1 or 2 of them per cycle, in order.
module fifo_dual_deq
    import fifo_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int QUEUE_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              in_valid,
    input  logic                              in_enque_en,
    input  logic [DWIDTH-1:0]                 in_data,
    output logic                              outA_valid,
    output logic [DWIDTH-1:0]                 outA_data,
    output logic                              outB_valid,
    output logic [DWIDTH-1:0]                 outB_data,
    input  logic                              outA_deque_en,
    input  logic                              outB_deque_en,
    output logic [cnt_width(QUEUE_SIZE)-1:0]  occupancy,
    output logic                              order_err
);

    localparam int PW = ptr_width(QUEUE_SIZE);
    localparam int CW = cnt_width(QUEUE_SIZE);

    logic [DWIDTH-1:0] r_mem [QUEUE_SIZE];
    logic              r_order_err;

    logic [PW-1:0]     w_head;
    logic [PW-1:0]     w_head_p1;
    logic [PW-1:0]     w_tail;
    logic [CW-1:0]     w_cnt;
    logic              w_push;
    logic              w_in_valid;
    logic              w_a_valid;
    logic              w_b_valid;
    fifo_err_e         w_err;

    fifo_ptr_ctrl #(
        .QUEUE_SIZE (QUEUE_SIZE)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enque_en (in_enque_en),
        .i_deque_a  (outA_deque_en),
        .i_deque_b  (outB_deque_en),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_cnt      (w_cnt),
        .o_push     (w_push),
        .o_in_valid (w_in_valid),
        .o_a_valid  (w_a_valid),
        .o_b_valid  (w_b_valid)
    );

    // Second entry lives one slot after the head, wrapping to index 0.
    assign w_head_p1 = w_head + PW'(1);

    // A second-lane pop without a head pop is an ordering violation.
    assign w_err = (outB_deque_en && !outA_deque_en) ? ORDER_ERR : ERR_NONE;

    // Storage write; popped slots are left stale and hidden by the masks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_tail] <= in_data;
        end
    end

    // Sticky ordering-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_order_err <= 1'b0;
        end else if (w_err == ORDER_ERR) begin
            r_order_err <= 1'b1;
        end
    end

    assign in_valid   = w_in_valid;
    assign outA_valid = w_a_valid;
    assign outB_valid = w_b_valid;
    assign outA_data  = w_a_valid ? r_mem[w_head]    : '0;
    assign outB_data  = w_b_valid ? r_mem[w_head_p1] : '0;
    assign occupancy  = w_cnt;
    assign order_err  = r_order_err;

endmodule
